tod_receiver: RTL and testbench

Time-of-day receiver for the event-receiver (EVR) path. It decodes the serial seconds value delivered as shift-0/shift-1 event codes and latches it at each seconds-marker event. It maintains a free-running fractional-second count from the local clock and presents a 64-bit {seconds, fraction} timestamp with validity and error counters. It sits directly downstream of the EVR event-code decoder, in the same clock domain.

---
 rtl/tod_receiver_pkg.sv | 21 ++
 rtl/tod_receiver_if.sv | 8 +
 rtl/tod_err_counter.sv | 28 ++
 rtl/tod_receiver.sv | 161 ++++++++++++++++
 tb/tb_tod_receiver.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/tod_receiver_pkg.sv
// Shared constants and helpers for the EVR time-of-day receiver.
// Event codes, default widths and the per-clock fraction increment.
package tod_receiver_pkg;

  localparam logic [7:0] TOD_DEF_EVCODE_SHIFT_ZERO     = 8'h70;
  localparam logic [7:0] TOD_DEF_EVCODE_SHIFT_ONE      = 8'h71;
  localparam logic [7:0] TOD_DEF_EVCODE_SECONDS_MARKER = 8'h7D;
  localparam int unsigned TOD_DEF_TIMESTAMP_WIDTH      = 32'd64;
  localparam int unsigned TOD_DEF_COUNTER_WIDTH        = 32'd16;

  // floor(2^frac_width / clk_rate), the fraction advance per local clock
  function automatic logic [63:0] frac_inc(input int unsigned clk_rate,
                                           input int unsigned frac_width);
    logic [127:0] pow_v;
    logic [127:0] quot_v;
    pow_v  = 128'd1 << frac_width;
    quot_v = pow_v / {96'd0, clk_rate};
    return quot_v[63:0];
  endfunction

endpackage

// File: rtl/tod_receiver_if.sv
// Event-code bus from the EVR decoder into the time-of-day receiver.
interface tod_receiver_if;
  logic [7:0] evCode;
  logic       evCodeValid;

  modport master (output evCode, output evCodeValid);
  modport slave  (input  evCode, input  evCodeValid);
endinterface

// File: rtl/tod_err_counter.sv
// Wrapping error counter advanced by a single-cycle increment strobe.
module tod_err_counter #(
  parameter int unsigned WIDTH = 32'd16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;

  // Count strobes; wraps naturally modulo 2^WIDTH
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + ONE;
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tod_receiver.sv
// Time-of-day receiver: decodes serial seconds from shift event codes, latches
// them on the seconds marker and runs a local fractional-second counter.
module tod_receiver
  import tod_receiver_pkg::*;
#(
  parameter int unsigned NOMINAL_CLK_RATE      = 32'd125_000_000,
  parameter int unsigned TIMESTAMP_WIDTH       = TOD_DEF_TIMESTAMP_WIDTH,
  parameter logic [7:0]  EVCODE_SHIFT_ZERO     = TOD_DEF_EVCODE_SHIFT_ZERO,
  parameter logic [7:0]  EVCODE_SHIFT_ONE      = TOD_DEF_EVCODE_SHIFT_ONE,
  parameter logic [7:0]  EVCODE_SECONDS_MARKER = TOD_DEF_EVCODE_SECONDS_MARKER,
  parameter int unsigned COUNTER_WIDTH         = TOD_DEF_COUNTER_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  tod_receiver_if.slave              ev,
  output logic [COUNTER_WIDTH-1:0]   tooManyBitsCounter,
  output logic [COUNTER_WIDTH-1:0]   tooFewBitsCounter,
  output logic [COUNTER_WIDTH-1:0]   outOfSeqCounter,
  output logic [TIMESTAMP_WIDTH-1:0] timestamp,
  output logic                       timestampValid
);

  localparam int unsigned SW  = TIMESTAMP_WIDTH / 32'd2;
  localparam int unsigned FW  = TIMESTAMP_WIDTH - SW;
  localparam int unsigned BCW = $clog2(SW + 32'd2);

  localparam logic [FW-1:0]  FRAC_INC = FW'(frac_inc(NOMINAL_CLK_RATE, FW));
  localparam logic [BCW-1:0] BC_FULL  = BCW'(SW);
  localparam logic [BCW-1:0] BC_OVER  = BCW'(SW + 32'd1);
  localparam logic [BCW-1:0] BC_ONE   = {{(BCW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]  SEC_ONE  = {{(SW-1){1'b0}}, 1'b1};

  logic [SW-1:0]  shift_q,    shift_d;
  logic [BCW-1:0] bit_cnt_q,  bit_cnt_d;
  logic [SW-1:0]  seconds_q,  seconds_d;
  logic [FW-1:0]  fraction_q, fraction_d;
  logic           valid_q,    valid_d;

  logic           is_shift_s;
  logic           shift_bit_s;
  logic           is_marker_s;
  logic           many_inc_s;
  logic           few_inc_s;
  logic           oos_inc_s;
  logic [SW-1:0]  seconds_inc_s;
  logic [FW:0]    frac_sum_s;

  assign seconds_inc_s = seconds_q + SEC_ONE;
  assign frac_sum_s    = {1'b0, fraction_q} + {1'b0, FRAC_INC};

  // Classify the incoming event code; anything unrecognised is ignored
  always_comb begin
    is_shift_s  = 1'b0;
    shift_bit_s = 1'b0;
    is_marker_s = 1'b0;
    if (ev.evCodeValid) begin
      if (ev.evCode == EVCODE_SHIFT_ZERO) begin
        is_shift_s = 1'b1;
      end else if (ev.evCode == EVCODE_SHIFT_ONE) begin
        is_shift_s  = 1'b1;
        shift_bit_s = 1'b1;
      end else if (ev.evCode == EVCODE_SECONDS_MARKER) begin
        is_marker_s = 1'b1;
      end else begin
        is_shift_s = 1'b0;
      end
    end else begin
      is_marker_s = 1'b0;
    end
  end

  // Next-state logic for shifter, bit count, seconds, fraction and lock
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    seconds_d  = seconds_q;
    fraction_d = fraction_q;
    valid_d    = valid_q;
    many_inc_s = 1'b0;
    few_inc_s  = 1'b0;
    oos_inc_s  = 1'b0;

    if (is_shift_s) begin
      shift_d = {shift_q[SW-2:0], shift_bit_s};
      if (bit_cnt_q == BC_OVER) begin
        bit_cnt_d = bit_cnt_q;
      end else begin
        bit_cnt_d = bit_cnt_q + BC_ONE;
      end
      // Only the full->over transition counts, so it fires once per second
      many_inc_s = (bit_cnt_q == BC_FULL);
    end else begin
      shift_d = shift_q;
    end

    if (is_marker_s) begin
      fraction_d = '0;
      bit_cnt_d  = '0;
      if (bit_cnt_q == BC_FULL) begin
        seconds_d = shift_q;
        valid_d   = 1'b1;
        oos_inc_s = valid_q && (shift_q != seconds_inc_s);
      end else if (bit_cnt_q < BC_FULL) begin
        few_inc_s = 1'b1;
        seconds_d = seconds_inc_s;
        valid_d   = 1'b0;
      end else begin
        seconds_d = seconds_inc_s;
        valid_d   = 1'b0;
      end
    end else if (frac_sum_s[FW]) begin
      // No marker arrived in time: pin the fraction and drop lock
      fraction_d = '1;
      valid_d    = 1'b0;
    end else begin
      fraction_d = frac_sum_s[FW-1:0];
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      seconds_q  <= '0;
      fraction_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      seconds_q  <= seconds_d;
      fraction_q <= fraction_d;
      valid_q    <= valid_d;
    end
  end

  tod_err_counter #(.WIDTH(COUNTER_WIDTH)) u_many_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (many_inc_s),
    .count_o (tooManyBitsCounter)
  );

  tod_err_counter #(.WIDTH(COUNTER_WIDTH)) u_few_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (few_inc_s),
    .count_o (tooFewBitsCounter)
  );

  tod_err_counter #(.WIDTH(COUNTER_WIDTH)) u_oos_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (oos_inc_s),
    .count_o (outOfSeqCounter)
  );

  assign timestamp      = {seconds_q, fraction_q};
  assign timestampValid = valid_q;

endmodule

// File: tb/tb_tod_receiver.sv
// Directed, scoreboarded bench for tod_receiver with a reduced clock rate so
// that marker loss (fraction overflow) is reachable in about a thousand cycles.
module tb_tod_receiver;

  localparam int unsigned     CLK_RATE = 32'd1000;
  localparam longint unsigned FI       = 64'h1_0000_0000 / 64'd1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] many_cnt, few_cnt, oos_cnt;
  logic [63:0] ts;
  logic        ts_valid;

  tod_receiver_if ev_if ();

  tod_receiver #(.NOMINAL_CLK_RATE(CLK_RATE)) dut (
    .clk                (clk),
    .rst                (rst),
    .ev                 (ev_if),
    .tooManyBitsCounter (many_cnt),
    .tooFewBitsCounter  (few_cnt),
    .outOfSeqCounter    (oos_cnt),
    .timestamp          (ts),
    .timestampValid     (ts_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] sec;
    logic [31:0] frac;
    logic        vld;
    logic [15:0] many;
    logic [15:0] few;
    logic [15:0] oos;
  } exp_t;

  exp_t            sbq[$];
  int              tests = 0;
  int              fails = 0;
  longint unsigned n_frac = 0;

  function automatic logic [31:0] exp_frac(input longint unsigned n);
    longint unsigned p;
    p = n * FI;
    if (p > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    else return p[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c);
    ev_if.evCode      = c;
    ev_if.evCodeValid = v;
    tick();
    if (rst === 1'b0) n_frac = 0;
    else if (v && c == 8'h7D) n_frac = 0;
    else n_frac = n_frac + 1;
  endtask

  task automatic shift_bits(input logic [63:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      drive(1'b1, w[i] ? 8'h71 : 8'h70);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] sec, input logic [31:0] frac,
                      input logic vld, input logic [15:0] many, input logic [15:0] few,
                      input logic [15:0] oos);
    exp_t e;
    e.tag = tag; e.sec = sec; e.frac = frac; e.vld = vld;
    e.many = many; e.few = few; e.oos = oos;
    sbq.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    tests++;
    assert (sbq.size() != 0) else begin
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      cmp(e.tag, "seconds",  {32'd0, ts[63:32]}, {32'd0, e.sec});
      cmp(e.tag, "fraction", {32'd0, ts[31:0]},  {32'd0, e.frac});
      cmp(e.tag, "valid",    {63'd0, ts_valid},  {63'd0, e.vld});
      cmp(e.tag, "many",     {48'd0, many_cnt},  {48'd0, e.many});
      cmp(e.tag, "few",      {48'd0, few_cnt},   {48'd0, e.few});
      cmp(e.tag, "oos",      {48'd0, oos_cnt},   {48'd0, e.oos});
    end
  endtask

  task automatic check_now(input string tag, input logic [31:0] sec, input logic vld,
                           input logic [15:0] many, input logic [15:0] few,
                           input logic [15:0] oos);
    push(tag, sec, exp_frac(n_frac), vld, many, few, oos);
    pop_check();
  endtask

  task automatic marker(input string tag, input logic [31:0] sec, input logic vld,
                        input logic [15:0] many, input logic [15:0] few,
                        input logic [15:0] oos);
    push(tag, sec, 32'd0, vld, many, few, oos);
    drive(1'b1, 8'h7D);
    pop_check();
  endtask

  initial begin
    ev_if.evCode      = 8'h00;
    ev_if.evCodeValid = 1'b0;
    rst = 1'b0;
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h71);
    check_now("reset", 32'd0, 1'b0, 16'd0, 16'd0, 16'd0);

    rst = 1'b1;
    shift_bits(64'h1234_5677, 32);
    check_now("preload", 32'd0, 1'b0, 16'd0, 16'd0, 16'd0);
    marker("clean", 32'h1234_5677, 1'b1, 16'd0, 16'd0, 16'd0);

    // Codes without valid, and unrelated valid codes, must change nothing
    drive(1'b0, 8'h7D);
    drive(1'b0, 8'h71);
    drive(1'b1, 8'h55);
    for (int i = 0; i < 150; i++) drive(1'b0, 8'h7D);
    check_now("ignored", 32'h1234_5677, 1'b1, 16'd0, 16'd0, 16'd0);

    shift_bits(64'h1234_5678, 32);
    check_now("pre_marker", 32'h1234_5677, 1'b1, 16'd0, 16'd0, 16'd0);
    marker("in_seq", 32'h1234_5678, 1'b1, 16'd0, 16'd0, 16'd0);

    shift_bits(64'h1234_5677, 32);
    marker("repeat", 32'h1234_5677, 1'b1, 16'd0, 16'd0, 16'd1);

    shift_bits(64'h7FFF_FFFF, 31);
    check_now("few_pre", 32'h1234_5677, 1'b1, 16'd0, 16'd0, 16'd1);
    marker("too_few", 32'h1234_5678, 1'b0, 16'd0, 16'd1, 16'd1);

    shift_bits(64'h1_5555_5555, 33);
    check_now("many_33", 32'h1234_5678, 1'b0, 16'd1, 16'd1, 16'd1);
    drive(1'b1, 8'h71);
    check_now("many_34", 32'h1234_5678, 1'b0, 16'd1, 16'd1, 16'd1);
    marker("too_many", 32'h1234_5679, 1'b0, 16'd1, 16'd1, 16'd1);

    // Re-lock from invalid: no sequence check against the old seconds
    shift_bits(64'h0000_00AA, 32);
    marker("relock", 32'h0000_00AA, 1'b1, 16'd1, 16'd1, 16'd1);
    shift_bits(64'h0000_00AB, 32);
    marker("after_relock", 32'h0000_00AB, 1'b1, 16'd1, 16'd1, 16'd1);

    for (int i = 0; i < 1000; i++) drive(1'b0, 8'h00);
    check_now("frac_edge", 32'h0000_00AB, 1'b1, 16'd1, 16'd1, 16'd1);
    drive(1'b0, 8'h00);
    check_now("frac_sat", 32'h0000_00AB, 1'b0, 16'd1, 16'd1, 16'd1);
    drive(1'b0, 8'h00);
    check_now("frac_hold", 32'h0000_00AB, 1'b0, 16'd1, 16'd1, 16'd1);

    // Partial bits before reset must be discarded
    shift_bits(64'h0000_03FF, 10);
    rst = 1'b0;
    drive(1'b1, 8'h71);
    check_now("reset2", 32'd0, 1'b0, 16'd0, 16'd0, 16'd0);
    rst = 1'b1;
    shift_bits(64'hCAFE_F00D, 32);
    marker("post_reset", 32'hCAFE_F00D, 1'b1, 16'd0, 16'd0, 16'd0);
    marker("zero_bits", 32'hCAFE_F00E, 1'b0, 16'd0, 16'd1, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
